// File: rtl/runner_frame_sequencer.sv
// runner_frame_sequencer: top-level sequencer for the running-man sprite/floor
// datapath on the 160x120 plot bus. After start it commands one floor draw,
// then loops once per frame: load origin, draw man, wait frame tick, erase,
// update jump/crouch physics.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start, jump, crouch     level requests from the player/controller
//   pause                   (only when RUNNER_PAUSE_EN is defined) holds WAIT
//   draw_floors_finish,
//   draw_man_finish,
//   erase_finish            sticky done flags from the datapath (rising edge used)
//   drawing_floors, draw_man, erase   datapath enables (one at a time)
//   ld_x, ld_y              one-cycle origin load strobes
//   x_out, y_out            man origin
//   normal1crouch0          posture (1 = standing, 0 = crouched)
//   frame_count             completed frames, wraps at 16 bits
//   busy                    high whenever not idle
//
// Optional feature macro: RUNNER_PAUSE_EN (adds the pause input).
module runner_frame_sequencer #(
  parameter int unsigned X_START      = 30,
  parameter int unsigned Y_GROUND     = 108,
  parameter int unsigned JUMP_FRAMES  = 12,
  parameter int unsigned FRAME_CYCLES = 833333
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        jump,
  input  logic        crouch,
`ifdef RUNNER_PAUSE_EN
  input  logic        pause,
`endif
  input  logic        draw_floors_finish,
  input  logic        draw_man_finish,
  input  logic        erase_finish,
  output logic        drawing_floors,
  output logic        draw_man,
  output logic        erase,
  output logic        ld_x,
  output logic        ld_y,
  output logic [7:0]  x_out,
  output logic [6:0]  y_out,
  output logic        normal1crouch0,
  output logic [15:0] frame_count,
  output logic        busy
);

  localparam int unsigned CNT_W    = $clog2(FRAME_CYCLES + 1);
  localparam int unsigned PH_W     = $clog2(2 * JUMP_FRAMES + 1);
  localparam int unsigned FIN_W    = 3;
  localparam logic [6:0]  Y_GND    = 7'(Y_GROUND);
  localparam logic [PH_W-1:0] PH_ASC  = PH_W'(JUMP_FRAMES);
  localparam logic [PH_W-1:0] PH_LAND = PH_W'(2 * JUMP_FRAMES - 1);

  typedef enum logic [2:0] {
    IDLE, FLOORS, LOAD, DRAW, WAIT, ERASE, UPDATE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  frame_cyc;
  logic              frame_tick;
  logic [PH_W-1:0]   phase;
  logic              jump_pend;
  logic              jump_set;
  logic              wait_exit;
  logic [FIN_W-1:0]  fin_cur;
  logic [FIN_W-1:0]  fin_prev;
  logic [FIN_W-1:0]  fin_rise;

  assign x_out      = 8'(X_START);
  assign frame_tick = (frame_cyc == CNT_W'(FRAME_CYCLES - 1));
  assign fin_rise   = fin_cur & ~fin_prev;

`ifdef RUNNER_PAUSE_EN
  assign jump_set  = jump & ~pause;
  assign wait_exit = frame_tick & ~pause;
`else
  assign jump_set  = jump;
  assign wait_exit = frame_tick;
`endif

  // Free-running frame timer; frame_tick marks its wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cyc <= '0;
    end else if (frame_tick) begin
      frame_cyc <= '0;
    end else begin
      frame_cyc <= frame_cyc + CNT_W'(1);
    end
  end

  // Finish flag edge detectors: bit 0 floors, bit 1 man, bit 2 erase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fin_cur  <= '0;
      fin_prev <= '0;
    end else begin
      fin_cur  <= {erase_finish, draw_man_finish, draw_floors_finish};
      fin_prev <= fin_cur;
    end
  end

  // Sequencer FSM with registered strobes, posture and jump physics.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      drawing_floors <= 1'b0;
      draw_man       <= 1'b0;
      erase          <= 1'b0;
      ld_x           <= 1'b0;
      ld_y           <= 1'b0;
      y_out          <= Y_GND;
      normal1crouch0 <= 1'b1;
      frame_count    <= '0;
      busy           <= 1'b0;
      phase          <= '0;
      jump_pend      <= 1'b0;
    end else begin
      ld_x <= 1'b0;
      ld_y <= 1'b0;
      if (jump_set) jump_pend <= 1'b1;
      case (state)
        IDLE: begin
          jump_pend <= 1'b0;
          if (start) begin
            state          <= FLOORS;
            drawing_floors <= 1'b1;
            busy           <= 1'b1;
          end
        end
        FLOORS: begin
          if (fin_rise[0]) begin
            state          <= LOAD;
            drawing_floors <= 1'b0;
            ld_x           <= 1'b1;
            ld_y           <= 1'b1;
          end
        end
        LOAD: begin
          state    <= DRAW;
          draw_man <= 1'b1;
        end
        DRAW: begin
          if (fin_rise[1]) begin
            state    <= WAIT;
            draw_man <= 1'b0;
          end
        end
        WAIT: begin
          if (wait_exit) begin
            state       <= ERASE;
            erase       <= 1'b1;
            frame_count <= frame_count + 16'd1;
          end
        end
        ERASE: begin
          if (fin_rise[2]) begin
            state <= UPDATE;
            erase <= 1'b0;
          end
        end
        UPDATE: begin
          state <= LOAD;
          ld_x  <= 1'b1;
          ld_y  <= 1'b1;
          if (phase == '0) begin
            // A jump held during this very cycle counts as pending too.
            if (jump_pend || jump_set) begin
              phase          <= PH_W'(1);
              y_out          <= Y_GND - 7'd1;
              normal1crouch0 <= 1'b1;
              jump_pend      <= 1'b0;
            end else begin
              y_out          <= Y_GND;
              normal1crouch0 <= ~crouch;
            end
          end else if (phase < PH_ASC) begin
            y_out          <= y_out - 7'd1;
            phase          <= phase + PH_W'(1);
            normal1crouch0 <= 1'b1;
          end else if (phase == PH_LAND) begin
            y_out          <= Y_GND;
            phase          <= '0;
            normal1crouch0 <= 1'b1;
          end else begin
            y_out          <= y_out + 7'd1;
            phase          <= phase + PH_W'(1);
            normal1crouch0 <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_runner_frame_sequencer.sv
// Testbench for runner_frame_sequencer: directed hand sequences for start-up,
// sticky finish flags and reset, plus a per-frame vector table for jump/crouch.
module tb_runner_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, jump, crouch;
  logic        pause;
  logic        auto_dp;
  logic        m_df, m_dm, m_er;
  logic        a_df, a_dm, a_er;
  wire         draw_floors_finish = auto_dp ? a_df : m_df;
  wire         draw_man_finish    = auto_dp ? a_dm : m_dm;
  wire         erase_finish       = auto_dp ? a_er : m_er;
  logic        drawing_floors, draw_man, erase, ld_x, ld_y, normal1crouch0, busy;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [15:0] frame_count;

  int errors = 0;
  int checks = 0;

  runner_frame_sequencer #(
    .X_START(30), .Y_GROUND(108), .JUMP_FRAMES(3), .FRAME_CYCLES(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .jump(jump), .crouch(crouch),
`ifdef RUNNER_PAUSE_EN
    .pause(pause),
`endif
    .draw_floors_finish(draw_floors_finish), .draw_man_finish(draw_man_finish),
    .erase_finish(erase_finish), .drawing_floors(drawing_floors),
    .draw_man(draw_man), .erase(erase), .ld_x(ld_x), .ld_y(ld_y),
    .x_out(x_out), .y_out(y_out), .normal1crouch0(normal1crouch0),
    .frame_count(frame_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       jump;
    logic       crouch;
    logic [6:0] y;
    logic       post;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return drawing_floors;
      1: return draw_man;
      2: return erase;
      default: return ld_x;
    endcase
  endfunction

  // Steps posedge+#1 until the selected strobe equals lvl, within budget.
  task automatic wait_sig(input int sel, input logic lvl, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk); #1;
      if (sig(sel) == lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Datapath model: raises a finish flag 3 cycles into its strobe, clears it when idle.
  initial begin
    int c_df, c_dm, c_er;
    c_df = 0; c_dm = 0; c_er = 0;
    a_df = 1'b0; a_dm = 1'b0; a_er = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (drawing_floors) begin c_df++; if (c_df >= 3) a_df = 1'b1; end
      else begin c_df = 0; a_df = 1'b0; end
      if (draw_man) begin c_dm++; if (c_dm >= 3) a_dm = 1'b1; end
      else begin c_dm = 0; a_dm = 1'b0; end
      if (erase) begin c_er++; if (c_er >= 3) a_er = 1'b1; end
      else begin c_er = 0; a_er = 1'b0; end
    end
  end

  // Exclusivity of strobes and ld_x/ld_y pairing, every cycle out of reset.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk("strobe_onehot", 32'($countones({drawing_floors, draw_man, erase, ld_x}) <= 1), 32'd1);
        chk("ld_pair", 32'(ld_x), 32'(ld_y));
      end
    end
  end

  task automatic set_vec(input int i, input logic j, input logic c, input logic [6:0] y, input logic p);
    vecs[i].jump = j; vecs[i].crouch = c; vecs[i].y = y; vecs[i].post = p;
  endtask

  initial begin
    bit ok;
    bit saw_er;
    int df_hi;
    int dm_hold;
    logic [15:0] fc_saved;

    set_vec(0,  0, 0, 108, 1); set_vec(1,  1, 0, 107, 1); set_vec(2,  0, 0, 106, 1);
    set_vec(3,  0, 1, 105, 1); set_vec(4,  0, 1, 106, 1); set_vec(5,  0, 0, 107, 1);
    set_vec(6,  0, 0, 108, 1); set_vec(7,  0, 0, 108, 1); set_vec(8,  1, 1, 107, 1);
    set_vec(9,  0, 1, 106, 1); set_vec(10, 0, 1, 105, 1); set_vec(11, 0, 1, 106, 1);
    set_vec(12, 0, 1, 107, 1); set_vec(13, 0, 1, 108, 1); set_vec(14, 0, 1, 108, 0);

    reset_n = 1'b0; start = 1'b0; jump = 1'b0; crouch = 1'b0; pause = 1'b0;
    auto_dp = 1'b0; m_df = 1'b0; m_dm = 1'b0; m_er = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_floors", 32'(drawing_floors), 0);
    chk("rst_draw_man", 32'(draw_man), 0);
    chk("rst_erase", 32'(erase), 0);
    chk("rst_ld", 32'(ld_x | ld_y), 0);
    chk("rst_x", 32'(x_out), 30);
    chk("rst_y", 32'(y_out), 108);
    chk("rst_posture", 32'(normal1crouch0), 1);
    chk("rst_fc", 32'(frame_count), 0);
    chk("rst_busy", 32'(busy), 0);

    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_start", 32'(busy), 0);

    // Start-up: floors finish raised after the 4th floors cycle; man flag already sticky.
    start = 1'b1;
    df_hi = 0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (drawing_floors) df_hi++;
    end
    m_df = 1'b1;
    m_dm = 1'b1;
    @(posedge clk); #1;
    if (drawing_floors) df_hi++;
    @(posedge clk); #1;
    if (drawing_floors) df_hi++;
    chk("floors_cycles", 32'(df_hi), 5);
    chk("load_ld_x", 32'(ld_x), 1);
    chk("load_ld_y", 32'(ld_y), 1);
    chk("load_busy", 32'(busy), 1);
    @(posedge clk); #1;
    chk("draw_ld_clear", 32'(ld_x), 0);
    chk("draw_man_on", 32'(draw_man), 1);
    chk("draw_x", 32'(x_out), 30);
    chk("draw_y", 32'(y_out), 108);

    // Sticky man flag must not advance DRAW until it falls and rises again.
    dm_hold = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (draw_man) dm_hold++;
    end
    chk("sticky_hold", 32'(dm_hold), 6);
    m_dm = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_dm = 1'b1;
    @(posedge clk); #1;
    chk("rise_still_draw", 32'(draw_man), 1);
    @(posedge clk); #1;
    chk("rise_enter_wait", 32'(draw_man), 0);
    chk("wait_no_erase", 32'(erase), 0);
    chk("wait_busy", 32'(busy), 1);
    m_df = 1'b0;
    m_dm = 1'b0;
    auto_dp = 1'b1;

    // Per-frame table: inputs applied during frame i, results seen at load i+1.
    for (int i = 0; i < 15; i++) begin
      crouch = vecs[i].crouch;
      if (vecs[i].jump) begin
        jump = 1'b1;
        @(posedge clk); #1;
        jump = 1'b0;
      end
      saw_er = 1'b0;
      ok = 1'b0;
      for (int n = 0; n < 200; n++) begin
        @(posedge clk); #1;
        if (erase) saw_er = 1'b1;
        if (ld_x) begin ok = 1'b1; break; end
      end
      chk($sformatf("load_timeout_%0d", i), 32'(ok), 1);
      chk($sformatf("erase_seen_%0d", i), 32'(saw_er), 1);
      chk($sformatf("y_%0d", i), 32'(y_out), 32'(vecs[i].y));
      chk($sformatf("posture_%0d", i), 32'(normal1crouch0), 32'(vecs[i].post));
      chk($sformatf("fc_%0d", i), 32'(frame_count), 32'(i + 1));
    end

    // Asynchronous reset in the middle of an erase.
    wait_sig(2, 1'b1, 200, ok);
    chk("erase_reached", 32'(ok), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_erase", 32'(erase), 0);
    chk("arst_y", 32'(y_out), 108);
    chk("arst_posture", 32'(normal1crouch0), 1);
    chk("arst_fc", 32'(frame_count), 0);
    chk("arst_busy", 32'(busy), 0);
    crouch = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(busy), 0);

`ifdef RUNNER_PAUSE_EN
    // Pause holds WAIT: no erase and frame_count frozen.
    start = 1'b1;
    wait_sig(1, 1'b1, 200, ok);
    start = 1'b0;
    chk("pause_draw_reached", 32'(ok), 1);
    wait_sig(1, 1'b0, 200, ok);
    chk("pause_wait_reached", 32'(ok), 1);
    pause = 1'b1;
    fc_saved = frame_count;
    saw_er = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (erase) saw_er = 1'b1;
    end
    chk("pause_no_erase", 32'(saw_er), 0);
    chk("pause_fc_hold", 32'(frame_count), 32'(fc_saved));
    pause = 1'b0;
    wait_sig(2, 1'b1, 40, ok);
    chk("unpause_erase", 32'(ok), 1);
    chk("unpause_fc", 32'(frame_count), 32'(fc_saved + 16'd1));
`else
    fc_saved = frame_count;
    chk("idle_fc_hold", 32'(fc_saved), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/runner_frame_sequencer.md
Name: runner_frame_sequencer

Overview:
- Top-level sequencer for the running-man sprite/floor datapath on the 160x120 VGA plot bus.
- After start, commands one floor draw, then loops once per frame: load position, draw man, wait frame tick, erase, update physics.
- Owns the man's vertical position (jump arc) and posture (normal/crouch), and feeds both to the datapath.

Parameters:
- X_START, 30, fixed man column (8-bit)
- Y_GROUND, 108, man top row when standing on floor (7-bit)
- JUMP_FRAMES, 12, frames of ascent; descent takes the same count
- FRAME_CYCLES, 833333, clk cycles per frame tick (60 Hz at 50 MHz)

Ports:
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- start  in  1  level; begin game from IDLE
- jump  in  1  level; jump request
- crouch  in  1  level; crouch request
- draw_floors_finish  in  1  datapath floor-done flag (level, sticky)
- draw_man_finish  in  1  datapath sprite-done flag (level, sticky)
- erase_finish  in  1  datapath erase-done flag (level, sticky)
- drawing_floors  out  1  floor draw enable
- draw_man  out  1  sprite draw enable
- erase  out  1  sprite erase enable
- ld_x  out  1  load x_out into datapath origin
- ld_y  out  1  load y_out into datapath origin
- x_out  out  8  man origin x
- y_out  out  7  man origin y
- normal1crouch0  out  1  posture to datapath
- frame_count  out  16  completed frames, wraps at 65535->0
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: reset_n is asynchronous, active-low; clk is the clock. Reset forces:
  - state IDLE; all strobes 0
  - x_out=X_START, y_out=Y_GROUND, normal1crouch0=1
  - frame_count=0, jump phase 0, frame cycle counter 0, finish edge registers 0
  - Reset mid-operation abandons the current draw; no cleanup erase.
- Finish inputs are sticky levels. Each input is registered, and only its rising edge (cur=1, prev=0) is used. An edge arriving in a non-matching state is ignored.
- Frame counter: free-running 0..FRAME_CYCLES-1. frame_tick is a one-cycle pulse at the wrap.
- Pending-jump latch:
  - Set on any cycle with jump=1.
  - Cleared when consumed in UPDATE or when entering IDLE.
- States and transitions:
  - IDLE: start=1 -> FLOORS.
  - FLOORS: drawing_floors=1; rising edge of draw_floors_finish -> LOAD.
  - LOAD: ld_x=ld_y=1 for exactly 1 cycle -> DRAW.
  - DRAW: draw_man=1; rising edge of draw_man_finish -> WAIT.
  - WAIT: frame_tick -> ERASE. frame_count increments on that same cycle.
  - ERASE: erase=1; rising edge of erase_finish -> UPDATE. Posture and y are unchanged until UPDATE, so the erase covers the drawn sprite exactly.
  - UPDATE (1 cycle) -> LOAD.
- UPDATE physics, phase p in 0..2*JUMP_FRAMES:
  - p=0 (grounded) and pending jump: p=1, y_out=Y_GROUND-1, normal1crouch0=1. Jump wins over crouch when both are present.
  - p=0, no jump: normal1crouch0 = ~crouch; y_out=Y_GROUND.
  - 1<=p<JUMP_FRAMES: y_out-=1, p+=1.
  - JUMP_FRAMES<=p<2*JUMP_FRAMES: y_out+=1, p+=1; when the new p reaches 2*JUMP_FRAMES, p=0 and y_out=Y_GROUND exactly.
  - Crouch is ignored while airborne; posture is forced to 1.
  - Apex is Y_GROUND-JUMP_FRAMES. y_out is never below 0 and never above Y_GROUND.
- Strobe timing: drawing_floors, draw_man and erase are registered Moore outputs, asserted from the first cycle of their state. They deassert on the cycle after the qualifying finish edge. At most one strobe is high at any time.
- x_out is constant X_START.

Optional Feature:
- Macro: RUNNER_PAUSE_EN.
- Defined:
  - Adds input port pause (1-bit, level).
  - In WAIT, frame_tick is ignored while pause=1, so the sprite stays drawn and frame_count holds.
  - Pending-jump latch does not set while pause=1.
  - Other states are unaffected.
- Undefined: no pause port; WAIT exits on every frame_tick.

Test Plan:
- Reset, then start=1 (FRAME_CYCLES=16), with the datapath model raising draw_floors_finish 5 cycles later -> drawing_floors high 5 cycles; ld_x/ld_y pulse 1 cycle; draw_man high; x_out=30, y_out=108, busy=1.
- draw_man_finish already high (sticky) before DRAW is entered -> no advance until it falls and rises again; WAIT entered only on the rising edge.
- Steady loop, no inputs, 4 frames -> frame_count=4; y_out=108; strobe order LOAD, DRAW, WAIT, ERASE, UPDATE repeats; never two strobes high at once.
- jump pulse 1 cycle during WAIT, JUMP_FRAMES=3 -> y_out over successive loads 107, 106, 105, 106, 107, 108, then stays 108.
- crouch=1 and jump=1 together while grounded -> jump taken, normal1crouch0=1. crouch held after landing -> normal1crouch0=0 on the next load.
- reset_n low during ERASE -> outputs return to reset values immediately (asynchronously). With RUNNER_PAUSE_EN defined, pause=1 in WAIT for 40 cycles -> no ERASE and frame_count unchanged.
